// File: rtl/mul64_per_if.sv
// openMSP430-style peripheral bus between the multiplier initiator and the peripheral.
interface mul64_per_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (output per_addr, per_din, per_en, per_we, input per_dout);
    modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/mul64_per_master.sv
// Bus initiator that runs a full 32x32->64 multiply on the per_* multiplier peripheral:
// writes both operands, pulses the control register, reads back four result words.
module mul64_per_master #(
    parameter logic [13:0] BASE_ADDR = 14'hA0,
    parameter int          WAIT_CYC  = 0
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    mul64_per_if.master per
);

    localparam int WAIT_CLAMP = (WAIT_CYC > 15) ? 15 : ((WAIT_CYC < 0) ? 0 : WAIT_CYC);
    // Counter holds the remaining idle cycles after the current one, so it exits on zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CLAMP > 0) ? 4'(WAIT_CLAMP - 1) : 4'd0;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ALO, S_WR_AHI, S_WR_BLO, S_WR_BHI, S_CTL1, S_CTL0,
        S_WAIT, S_RD0, S_RD1, S_RD2, S_RD3, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [3:0]  wait_q, wait_d;
    logic [63:0] result_q, result_d;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            wait_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            wait_q   <= wait_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_WR_ALO;
            S_WR_ALO: state_d = S_WR_AHI;
            S_WR_AHI: state_d = S_WR_BLO;
            S_WR_BLO: state_d = S_WR_BHI;
            S_WR_BHI: state_d = S_CTL1;
            S_CTL1:   state_d = S_CTL0;
            S_CTL0:   state_d = (WAIT_CLAMP == 0) ? S_RD0 : S_WAIT;
            S_WAIT:   if (wait_q == 4'd0) state_d = S_RD0;
            S_RD0:    state_d = S_RD1;
            S_RD1:    state_d = S_RD2;
            S_RD2:    state_d = S_RD3;
            S_RD3:    state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, wait countdown, word-wise result assembly.
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        wait_d   = wait_q;
        result_d = result_q;
        if (state_q == S_IDLE && start) begin
            op_a_d = op_a;
            op_b_d = op_b;
        end
        if (state_q == S_CTL0)
            wait_d = WAIT_LOAD;
        else if (state_q == S_WAIT && wait_q != 4'd0)
            wait_d = wait_q - 4'd1;
        case (state_q)
            S_RD0:   result_d[15:0]  = per.per_dout;
            S_RD1:   result_d[31:16] = per.per_dout;
            S_RD2:   result_d[47:32] = per.per_dout;
            S_RD3:   result_d[63:48] = per.per_dout;
            default: ;
        endcase
    end

    // Bus outputs decode registered state only, so an idle or reset state drives all zeros.
    always_comb begin
        per.per_en   = 1'b0;
        per.per_we   = 2'b00;
        per.per_addr = 14'd0;
        per.per_din  = 16'd0;
        case (state_q)
            S_WR_ALO: begin per.per_en = 1'b1; per.per_we = 2'b11; per.per_addr = BASE_ADDR;         per.per_din = op_a_q[15:0];  end
            S_WR_AHI: begin per.per_en = 1'b1; per.per_we = 2'b11; per.per_addr = BASE_ADDR + 14'd1; per.per_din = op_a_q[31:16]; end
            S_WR_BLO: begin per.per_en = 1'b1; per.per_we = 2'b11; per.per_addr = BASE_ADDR + 14'd2; per.per_din = op_b_q[15:0];  end
            S_WR_BHI: begin per.per_en = 1'b1; per.per_we = 2'b11; per.per_addr = BASE_ADDR + 14'd3; per.per_din = op_b_q[31:16]; end
            S_CTL1:   begin per.per_en = 1'b1; per.per_we = 2'b11; per.per_addr = BASE_ADDR + 14'd8; per.per_din = 16'h0001;      end
            S_CTL0:   begin per.per_en = 1'b1; per.per_we = 2'b11; per.per_addr = BASE_ADDR + 14'd8; per.per_din = 16'h0000;      end
            S_RD0:    begin per.per_en = 1'b1; per.per_addr = BASE_ADDR + 14'd4; end
            S_RD1:    begin per.per_en = 1'b1; per.per_addr = BASE_ADDR + 14'd5; end
            S_RD2:    begin per.per_en = 1'b1; per.per_addr = BASE_ADDR + 14'd6; end
            S_RD3:    begin per.per_en = 1'b1; per.per_addr = BASE_ADDR + 14'd7; end
            default:  ;
        endcase
        busy   = (state_q != S_IDLE) && (state_q != S_DONE);
        done   = (state_q == S_DONE);
        result = result_q;
    end

endmodule

// File: tb/tb_mul64_per_master.sv
// Directed bench: two initiators (WAIT_CYC 0 and 3), each against a behavioural multiplier peripheral.
module tb_mul64_per_master;
    logic        mclk = 1'b0;
    logic        puc_rst = 1'b0;
    always #5 mclk = ~mclk;

    logic        start0 = 1'b0, start3 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a3 = '0, b3 = '0;
    logic        busy0, done0, busy3, done3;
    logic [63:0] res0, res3;

    mul64_per_if bus0 ();
    mul64_per_if bus3 ();

    mul64_per_master #(.BASE_ADDR(14'hA0), .WAIT_CYC(0)) u0 (
        .mclk(mclk), .puc_rst(puc_rst), .start(start0), .op_a(a0), .op_b(b0),
        .busy(busy0), .done(done0), .result(res0), .per(bus0.master));
    mul64_per_master #(.BASE_ADDR(14'hA0), .WAIT_CYC(3)) u3 (
        .mclk(mclk), .puc_rst(puc_rst), .start(start3), .op_a(a3), .op_b(b3),
        .busy(busy3), .done(done3), .result(res3), .per(bus3.master));

    // Peripheral model: product latched one cycle after a rising control bit.
    logic [31:0] m0_a, m0_b, m3_a, m3_b;
    logic [63:0] m0_p, m3_p;
    logic        m0_ctl, m0_pend, m3_ctl, m3_pend;

    always @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            m0_a <= '0; m0_b <= '0; m0_p <= '0; m0_ctl <= 1'b0; m0_pend <= 1'b0;
        end else begin
            m0_pend <= 1'b0;
            if (m0_pend) m0_p <= {32'd0, m0_a} * {32'd0, m0_b};
            if (bus0.per_en && bus0.per_we == 2'b11)
                case (bus0.per_addr)
                    14'hA0: m0_a[15:0]  <= bus0.per_din;
                    14'hA1: m0_a[31:16] <= bus0.per_din;
                    14'hA2: m0_b[15:0]  <= bus0.per_din;
                    14'hA3: m0_b[31:16] <= bus0.per_din;
                    14'hA8: begin m0_ctl <= bus0.per_din[0]; if (bus0.per_din[0] && !m0_ctl) m0_pend <= 1'b1; end
                    default: ;
                endcase
        end
    end
    always_comb begin
        bus0.per_dout = 16'h0;
        if (bus0.per_en && bus0.per_we == 2'b00)
            case (bus0.per_addr)
                14'hA4: bus0.per_dout = m0_p[15:0];
                14'hA5: bus0.per_dout = m0_p[31:16];
                14'hA6: bus0.per_dout = m0_p[47:32];
                14'hA7: bus0.per_dout = m0_p[63:48];
                default: ;
            endcase
    end

    always @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            m3_a <= '0; m3_b <= '0; m3_p <= '0; m3_ctl <= 1'b0; m3_pend <= 1'b0;
        end else begin
            m3_pend <= 1'b0;
            if (m3_pend) m3_p <= {32'd0, m3_a} * {32'd0, m3_b};
            if (bus3.per_en && bus3.per_we == 2'b11)
                case (bus3.per_addr)
                    14'hA0: m3_a[15:0]  <= bus3.per_din;
                    14'hA1: m3_a[31:16] <= bus3.per_din;
                    14'hA2: m3_b[15:0]  <= bus3.per_din;
                    14'hA3: m3_b[31:16] <= bus3.per_din;
                    14'hA8: begin m3_ctl <= bus3.per_din[0]; if (bus3.per_din[0] && !m3_ctl) m3_pend <= 1'b1; end
                    default: ;
                endcase
        end
    end
    always_comb begin
        bus3.per_dout = 16'h0;
        if (bus3.per_en && bus3.per_we == 2'b00)
            case (bus3.per_addr)
                14'hA4: bus3.per_dout = m3_p[15:0];
                14'hA5: bus3.per_dout = m3_p[31:16];
                14'hA6: bus3.per_dout = m3_p[47:32];
                14'hA7: bus3.per_dout = m3_p[63:48];
                default: ;
            endcase
    end

    logic [31:0] tr0[$];
    int          ndone0 = 0;
    always @(posedge mclk) begin
        if (!puc_rst && bus0.per_en) tr0.push_back({bus0.per_we, bus0.per_addr, bus0.per_din});
        if (done0) ndone0++;
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Advances until done of the selected instance; cyc is the run cycle number where done was seen.
    task automatic wait_done(input int which, input int from, output int cyc);
        cyc = from;
        while (!(which == 0 ? done0 : done3) && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run0(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input string tag);
        int c;
        a0 = a; b0 = b; start0 = 1'b1;
        tick();
        start0 = 1'b0; a0 = ~a; b0 = ~b;
        wait_done(0, 1, c);
        chk({tag, "_done_cyc"}, 64'(c), 64'd11);
        chk({tag, "_result"}, res0, exp);
    endtask

    function automatic logic [31:0] te(input logic [1:0] we, input logic [13:0] ad, input logic [15:0] d);
        return {we, ad, d};
    endfunction

    initial begin
        logic [31:0] exp_tr[10];
        int c, nd;
        exp_tr[0] = te(2'b11, 14'hA0, 16'h0003); exp_tr[1] = te(2'b11, 14'hA1, 16'h0000);
        exp_tr[2] = te(2'b11, 14'hA2, 16'h0005); exp_tr[3] = te(2'b11, 14'hA3, 16'h0000);
        exp_tr[4] = te(2'b11, 14'hA8, 16'h0001); exp_tr[5] = te(2'b11, 14'hA8, 16'h0000);
        exp_tr[6] = te(2'b00, 14'hA4, 16'h0000); exp_tr[7] = te(2'b00, 14'hA5, 16'h0000);
        exp_tr[8] = te(2'b00, 14'hA6, 16'h0000); exp_tr[9] = te(2'b00, 14'hA7, 16'h0000);

        // Asynchronous reset mid-clock, start held during reset.
        #2 puc_rst = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy0}, 64'd0);
        chk("rst_done", {63'd0, done0}, 64'd0);
        chk("rst_result", res0, 64'd0);
        chk("rst_bus", {bus0.per_en, bus0.per_we, bus0.per_addr, bus0.per_din}, 64'd0);
        start0 = 1'b1; start3 = 1'b1; a0 = 32'd9; b0 = 32'd9;
        repeat (3) tick();
        chk("rst_start_ignored", {busy0, busy3, bus0.per_en, bus3.per_en}, 64'd0);
        start0 = 1'b0; start3 = 1'b0;
        puc_rst = 1'b0;
        tick();

        // 3 x 5 with exact bus trace.
        tr0.delete();
        a0 = 32'd3; b0 = 32'd5; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("a_busy_c1", {63'd0, busy0}, 64'd1);
        wait_done(0, 1, c);
        chk("a_done_cyc", 64'(c), 64'd11);
        chk("a_busy_in_done", {63'd0, busy0}, 64'd0);
        chk("a_result", res0, 64'h0F);
        chk("a_trace_len", 64'(tr0.size()), 64'd10);
        for (int i = 0; i < 10 && i < tr0.size(); i++)
            chk($sformatf("a_trace%0d", i), {32'd0, tr0[i]}, {32'd0, exp_tr[i]});

        // Back-to-back runs.
        tick();
        run0(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "ones");
        tick();
        run0(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E_242D2080, "b2b");
        tick();

        // Start pulses at cycles 3 and 11 are ignored.
        nd = ndone0;
        a0 = 32'd7; b0 = 32'd9; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick();
        a0 = 32'd100; b0 = 32'd100; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done(0, 4, c);
        chk("ign_done_cyc", 64'(c), 64'd11);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("ign_busy_c12", {63'd0, busy0}, 64'd0);
        tick();
        chk("ign_busy_c13", {63'd0, busy0}, 64'd0);
        chk("ign_done_count", 64'(ndone0 - nd), 64'd1);
        chk("ign_result", res0, 64'h3F);

        // Reset during RD1, then a clean run.
        a0 = 32'd2; b0 = 32'd3; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (7) tick();
        chk("rd1_addr", {49'd0, bus0.per_en, bus0.per_addr}, {49'd0, 1'b1, 14'hA5});
        #2 puc_rst = 1'b1;
        #1;
        chk("rd1_rst_bus", {bus0.per_en, busy0, done0}, 64'd0);
        nd = ndone0;
        tick();
        puc_rst = 1'b0;
        repeat (3) tick();
        chk("rd1_no_done", 64'(ndone0 - nd), 64'd0);
        chk("rd1_idle", {busy0, bus0.per_en}, 64'd0);
        run0(32'd6, 32'd7, 64'h2A, "post_rst");

        // WAIT_CYC = 3 instance.
        a3 = 32'd3; b3 = 32'd5; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (5) tick();
        chk("w3_ctl0", {bus3.per_en, bus3.per_we, bus3.per_addr, bus3.per_din}, {31'd0, 1'b1, 2'b11, 14'hA8, 16'h0000});
        for (int k = 7; k <= 9; k++) begin
            tick();
            chk($sformatf("w3_idle_c%0d", k), {bus3.per_en, bus3.per_addr, bus3.per_din}, 64'd0);
        end
        tick();
        chk("w3_rd0", {bus3.per_en, bus3.per_we, bus3.per_addr}, {47'd0, 1'b1, 2'b00, 14'hA4});
        wait_done(3, 10, c);
        chk("w3_done_cyc", 64'(c), 64'd14);
        chk("w3_result", res3, 64'h0F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
